cpu_bus_master: RTL and testbench
=================================

# cpu_bus_master

Memory-side responder for the CPU pipeline's instruction and data request ports. It accepts the fetch request (`InstrReq`) and the load/store request (`DataReq`), drives their `InstrWait`/`DataWait` back to the hazard controller, and serialises both onto a single command/response system-bus port with one transaction outstanding. Data requests have priority over fetches. Abandoned fetches, such as those killed by a pipeline flush, are drained from the bus and their result is discarded.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `InstrReq`  in  1  fetch request; held high by CPU while `InstrWait`=1
- `InstrAddr`  in  ADDR_W  fetch address
- `InstrWait`  out  1  fetch not yet complete (combinational)
- `InstrRdata`  out  DATA_W  fetched word, valid in the cycle `InstrReq`=1 and `InstrWait`=0
- `DataReq`  in  1  load/store request; held high while `DataWait`=1
- `DataWrite`  in  1  1 = store, 0 = load
- `DataAddr`  in  ADDR_W  load/store address
- `DataWdata`  in  DATA_W  store data
- `DataStrb`  in  DATA_W/8  store byte enables
- `DataWait`  out  1  load/store not yet complete (combinational)
- `DataRdata`  out  DATA_W  load data, valid in the cycle `DataReq`=1 and `DataWait`=0
- `bus_valid`  out  1  command valid
- `bus_ready`  in  1  command accepted when `bus_valid`&`bus_ready`
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_strb`  out  1/ADDR_W/DATA_W/DATA_W/8  command fields
- `bus_resp_valid`  in  1  response pulse: read data, or write acknowledge
- `bus_rdata`  in  DATA_W  read data, sampled with `bus_resp_valid`

## Operation
- State machine: IDLE, CMD, RESP, DONE. An `owner` register (INSTR/DATA) and a command latch (we, addr, wdata, strb) are registered.
- IDLE:
  - If `DataReq`: latch the data command, owner=DATA, go to CMD.
  - Else if `InstrReq`: latch `InstrAddr` with we=0 and strb=all-ones, owner=INSTR, go to CMD.
  - Else stay in IDLE.
- CMD: `bus_valid`=1 with the latched fields. On `bus_ready`, go to RESP. `bus_valid` is never withdrawn before `bus_ready`, even if the requester drops.
- RESP: on `bus_resp_valid`, capture `bus_rdata` into a response register, then go to DONE. Write responses carry no data and the register is left unchanged.
- DONE, single cycle, then always back to IDLE. Delivery rules:
  - owner=DATA: always delivered. Loads copy the response register to `DataRdata`. `DataReq` is required to be high; the MEM stage is fully stalled.
  - owner=INSTR: delivered only if `InstrReq`=1 and `InstrAddr` equals the latched address. `InstrRdata` is loaded from the response register. Otherwise the result is discarded and `InstrRdata` is unchanged.
- `InstrWait` = `InstrReq` & ~(DONE & owner=INSTR & address match).
- `DataWait` = `DataReq` & ~(DONE & owner=DATA).
- A request not currently owned sees Wait=1 until it wins arbitration and completes.
- A request arriving or changing while another transaction is in flight is sampled only in IDLE.
- `InstrRdata`/`DataRdata` are registered and hold their last delivered value.

## Timing
- Reset values (asynchronous): state=IDLE, `bus_valid`=0, all bus command fields 0, `InstrRdata`=0, `DataRdata`=0. Wait outputs follow their formulas, so Wait equals Req.
- Reset mid-transaction returns to IDLE immediately; no response is delivered.
- Minimum latency with `bus_ready` and `bus_resp_valid` asserted at the earliest cycle:
  - request sampled in cycle 0 (IDLE)
  - command in cycle 1
  - response in cycle 2
  - Wait=0 in cycle 3
  - Wait is high for exactly 3 cycles.
- `bus_ready` stalls extend CMD one cycle each; response delay extends RESP one cycle each.
- Back-to-back: after DONE, IDLE takes one cycle before the next command. Minimum is 4 cycles per transaction.
- Simultaneous `InstrReq` and `DataReq` in IDLE: data is served first. The fetch starts in the IDLE cycle after the data DONE.
- A `bus_resp_valid` outside RESP is ignored.

## Test plan
- Single fetch, ready and response immediate: `InstrReq`=1, addr 0x100, `bus_rdata`=0xDEADBEEF → `bus_valid` cycle 1 with addr 0x100, `InstrWait` 1,1,1,0, `InstrRdata`=0xDEADBEEF in cycle 3.
- Store then load with `bus_ready` delayed 2 cycles:
  - store addr 0x20, wdata 0x12345678, strb 0xF → bus_we=1 held 3 cycles.
  - load addr 0x20 with response 0x12345678 → `DataRdata`=0x12345678, `DataWait` low for one cycle only.
- Simultaneous requests: `InstrReq` at 0x200 and `DataReq` load at 0x40 in the same cycle → bus sees 0x40 first, then 0x200. `InstrWait` stays high until the second DONE.
- Flushed fetch: fetch 0x300 accepted, then `InstrAddr` changes to 0x400 during RESP → 0x300 data discarded, `InstrRdata` unchanged, new command to 0x400, 0x400 data delivered.
- Reset mid-operation: assert `rst` in RESP → `bus_valid`=0 and outputs 0 immediately. After release, a new fetch completes in the normal 3-cycle minimum.

Source files
------------

// File: rtl/cpu_bus_master.sv
// Memory-side responder for the CPU fetch and load/store ports. Both ports are
// serialised onto one command/response bus, one transaction at a time, data first.
module cpu_bus_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  InstrReq,
  input  logic [ADDR_W-1:0]     InstrAddr,
  output logic                  InstrWait,
  output logic [DATA_W-1:0]     InstrRdata,

  input  logic                  DataReq,
  input  logic                  DataWrite,
  input  logic [ADDR_W-1:0]     DataAddr,
  input  logic [DATA_W-1:0]     DataWdata,
  input  logic [DATA_W/8-1:0]   DataStrb,
  output logic                  DataWait,
  output logic [DATA_W-1:0]     DataRdata,

  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_strb,
  input  logic                  bus_resp_valid,
  input  logic [DATA_W-1:0]     bus_rdata
);

  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

  state_t                state, state_next;
  owner_t                owner;

  logic                  cmd_we;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;

  logic [DATA_W-1:0]     resp_data;
  logic [DATA_W-1:0]     instr_q;
  logic [DATA_W-1:0]     data_q;

  logic                  instr_deliver;
  logic                  data_deliver;
  logic                  resp_capture;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block is defaulted first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    bus_valid     = 1'b0;
    resp_capture  = 1'b0;
    instr_deliver = 1'b0;
    data_deliver  = 1'b0;
    unique case (state)
      IDLE: if (DataReq || InstrReq) state_next = CMD;
      CMD: begin
        bus_valid = 1'b1;
        if (bus_ready) state_next = RESP;
      end
      RESP: if (bus_resp_valid) begin
        resp_capture = ~cmd_we;
        state_next   = DONE;
      end
      DONE: begin
        state_next    = IDLE;
        data_deliver  = (owner == OWN_DATA);
        // A fetch is only handed back if the CPU still wants that exact address.
        instr_deliver = (owner == OWN_INSTR) && InstrReq && (InstrAddr == cmd_addr);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_INSTR;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_strb  <= '0;
    end else if (state == IDLE) begin
      if (DataReq) begin
        owner     <= OWN_DATA;
        cmd_we    <= DataWrite;
        cmd_addr  <= DataAddr;
        cmd_wdata <= DataWdata;
        cmd_strb  <= DataStrb;
      end else if (InstrReq) begin
        owner     <= OWN_INSTR;
        cmd_we    <= 1'b0;
        cmd_addr  <= InstrAddr;
        cmd_wdata <= '0;
        cmd_strb  <= '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data <= '0;
      instr_q   <= '0;
      data_q    <= '0;
    end else begin
      if (resp_capture)                 resp_data <= bus_rdata;
      if (instr_deliver)                instr_q   <= resp_data;
      if (data_deliver && !cmd_we)      data_q    <= resp_data;
    end
  end

  // The delivered word is presented in the DONE cycle itself, then held.
  assign InstrRdata = instr_deliver ? resp_data : instr_q;
  assign DataRdata  = (data_deliver && !cmd_we) ? resp_data : data_q;

  assign InstrWait  = InstrReq & ~instr_deliver;
  assign DataWait   = DataReq  & ~data_deliver;

  assign bus_we     = cmd_we;
  assign bus_addr   = cmd_addr;
  assign bus_wdata  = cmd_wdata;
  assign bus_strb   = cmd_strb;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Scoreboard bench for cpu_bus_master: directed scenarios plus randomized
// fetch/load/store traffic against a byte-level memory reference model.
module tb_cpu_bus_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        InstrReq, InstrWait;
  logic [31:0] InstrAddr, InstrRdata;
  logic        DataReq, DataWrite, DataWait;
  logic [31:0] DataAddr, DataWdata, DataRdata;
  logic [3:0]  DataStrb;
  logic        bus_valid, bus_ready, bus_we, bus_resp_valid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_strb;

  cpu_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .InstrReq(InstrReq), .InstrAddr(InstrAddr), .InstrWait(InstrWait), .InstrRdata(InstrRdata),
    .DataReq(DataReq), .DataWrite(DataWrite), .DataAddr(DataAddr), .DataWdata(DataWdata),
    .DataStrb(DataStrb), .DataWait(DataWait), .DataRdata(DataRdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_resp_valid(bus_resp_valid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } data_exp_t;

  data_exp_t   exp_data[$];
  logic [31:0] exp_instr[$];
  logic [31:0] bus_log[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  // Slave behaviour knobs
  bit rand_mode   = 1'b0;
  int fixed_ready = 0;
  int fixed_resp  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no DUT event within bound", name);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    bus_mem[a] = d;
  endtask

  // ---------------- bus slave ----------------
  logic        fire, fire_we;
  logic [31:0] fire_addr, fire_wdata, pend_rdata;
  logic [3:0]  fire_strb;
  bit          busy = 1'b0;
  int          vcnt = 0, rdy_delay = 0, resp_cnt = 0;

  initial begin
    bus_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      fire       = bus_valid && bus_ready && !rst;
      fire_we    = bus_we;
      fire_addr  = bus_addr;
      fire_wdata = bus_wdata;
      fire_strb  = bus_strb;
      if (rst) busy = 1'b0;
      @(posedge clk); #1;
      bus_resp_valid = 1'b0;
      bus_rdata      = $urandom;
      if (fire) begin
        if (fire_we) bus_mem[fire_addr] = merge(bus_read(fire_addr), fire_wdata, fire_strb);
        pend_rdata = fire_we ? 32'($urandom) : bus_read(fire_addr);
        resp_cnt   = rand_mode ? int'($urandom_range(0, 3)) : fixed_resp;
        busy       = 1'b1;
      end else if (busy && resp_cnt > 0) begin
        resp_cnt--;
      end
      if (busy && resp_cnt == 0 && !rst) begin
        bus_resp_valid = 1'b1;
        bus_rdata      = pend_rdata;
        busy           = 1'b0;
      end else if (!busy && !fire && rand_mode && $urandom_range(0, 7) == 0) begin
        bus_resp_valid = 1'b1;   // stray pulse outside a response window
      end
      if (bus_valid) begin
        if (vcnt == 0) rdy_delay = rand_mode ? int'($urandom_range(0, 2)) : fixed_ready;
        bus_ready = (vcnt >= rdy_delay);
        vcnt++;
      end else begin
        vcnt      = 0;
        bus_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        pv, pr, pwe;
    logic [31:0] pa, pw, e_i;
    logic [3:0]  ps;
    data_exp_t   e_d;
    pv = 1'b0; pr = 1'b0; pwe = 1'b0; pa = '0; pw = '0; ps = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("bus_valid_held", bus_valid, 1'b1);
        check("bus_cmd_stable", {bus_we, bus_addr, bus_wdata, bus_strb}, {pwe, pa, pw, ps});
      end
      pv = bus_valid; pr = bus_ready; pwe = bus_we; pa = bus_addr; pw = bus_wdata; ps = bus_strb;
      if (bus_valid && bus_ready) begin
        bus_log.push_back(bus_addr);
        if (bus_addr >= 32'h1000) check("fetch_cmd_fields", {bus_we, bus_strb}, {1'b0, 4'hF});
      end
      if (InstrReq && !InstrWait) begin
        if (exp_instr.size() == 0) fail_now("instr_unexpected_delivery");
        else begin
          e_i = exp_instr.pop_front();
          check("instr_rdata", InstrRdata, e_i);
        end
      end
      if (DataReq && !DataWait) begin
        if (exp_data.size() == 0) fail_now("data_unexpected_delivery");
        else begin
          e_d = exp_data.pop_front();
          if (!e_d.we) check("load_rdata", DataRdata, e_d.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers ----------------
  task automatic fetch_min(input string name, input logic [31:0] a, input logic [31:0] d);
    preload(a, d);
    InstrAddr = a;
    InstrReq  = 1'b1;
    exp_instr.push_back(ref_read(a));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check({name, "_wait"}, InstrWait, (c < 3));
      if (c == 1) check({name, "_cmd"}, {bus_valid, bus_addr}, {1'b1, a});
      if (c == 3) check({name, "_rdata"}, InstrRdata, d);
    end
    @(posedge clk); #1;
    InstrReq = 1'b0;
  endtask

  // ---------------- random drivers ----------------
  task automatic instr_driver(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int          cyc;
      bit          flushed;
      a = {20'h0, 4'h1, 6'($urandom_range(0, 63)), 2'b00};
      InstrAddr = a;
      InstrReq  = 1'b1;
      exp_instr.push_back(ref_read(a));
      cyc = 0; flushed = 1'b0;
      forever begin
        @(negedge clk);
        if (!InstrWait) break;
        if (++cyc > 1000) begin fail_now("instr_timeout"); break; end
        @(posedge clk); #1;
        if (!flushed && $urandom_range(0, 9) == 0) begin
          a = {20'h0, 4'h1, 6'($urandom_range(0, 63)), 2'b00};
          InstrAddr = a;
          exp_instr[exp_instr.size()-1] = ref_read(a);
          flushed = 1'b1;
        end
      end
      @(posedge clk); #1;
      InstrReq = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic data_driver(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int          cyc;
      data_exp_t   e;
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      DataAddr  = a;
      DataWrite = 1'($urandom_range(0, 1));
      DataWdata = $urandom;
      DataStrb  = 4'($urandom_range(1, 15));
      DataReq   = 1'b1;
      e.we   = DataWrite;
      e.data = DataWrite ? 32'h0 : ref_read(a);
      exp_data.push_back(e);
      if (DataWrite) ref_mem[a] = merge(ref_read(a), DataWdata, DataStrb);
      cyc = 0;
      forever begin
        @(negedge clk);
        if (!DataWait) break;
        if (++cyc > 1000) begin fail_now("data_timeout"); break; end
      end
      @(posedge clk); #1;
      DataReq = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- main sequence ----------------
  int          cyc_cnt, we_cyc, done_cyc, d_cyc, i_cyc;
  bit          drop_d;

  initial begin
    rst = 1'b1;
    InstrReq = 1'b0; InstrAddr = '0;
    DataReq = 1'b0; DataWrite = 1'b0; DataAddr = '0; DataWdata = '0; DataStrb = '0;
    repeat (2) @(posedge clk);
    #1;
    InstrReq = 1'b1;
    #1;
    check("rst_bus_valid", bus_valid, 1'b0);
    check("rst_bus_fields", {bus_we, bus_addr, bus_wdata, bus_strb}, 69'h0);
    check("rst_rdata", {InstrRdata, DataRdata}, 64'h0);
    check("rst_waits", {InstrWait, DataWait}, 2'b10);
    InstrReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch at minimum latency
    fetch_min("fetch1", 32'h100, 32'hDEADBEEF);

    // Store then load with two-cycle ready stall
    fixed_ready = 2;
    DataReq = 1'b1; DataWrite = 1'b1; DataAddr = 32'h20; DataWdata = 32'h12345678; DataStrb = 4'hF;
    exp_data.push_back('{we: 1'b1, data: 32'h0});
    ref_mem[32'h20] = merge(ref_read(32'h20), 32'h12345678, 4'hF);
    we_cyc = 0; done_cyc = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus_valid && bus_we) we_cyc++;
      if (!DataWait) begin done_cyc = c; break; end
    end
    check("store_we_cycles", we_cyc, 3);
    check("store_latency", done_cyc, 5);
    @(posedge clk); #1;
    DataWrite = 1'b0; DataWdata = '0;
    exp_data.push_back('{we: 1'b0, data: ref_read(32'h20)});
    done_cyc = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!DataWait) begin done_cyc = c; break; end
    end
    check("load_latency", done_cyc, 5);
    check("load_rdata_direct", DataRdata, 32'h12345678);
    @(posedge clk); #1;
    DataReq = 1'b0;
    fixed_ready = 0;
    @(posedge clk); #1;

    // Simultaneous requests: data first
    preload(32'h200, 32'hCAFE0200);
    preload(32'h40, 32'h44440040);
    bus_log.delete();
    InstrAddr = 32'h200; InstrReq = 1'b1;
    DataAddr = 32'h40; DataWrite = 1'b0; DataReq = 1'b1;
    exp_instr.push_back(ref_read(32'h200));
    exp_data.push_back('{we: 1'b0, data: ref_read(32'h40)});
    d_cyc = -1; i_cyc = -1; drop_d = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (DataReq && !DataWait) begin d_cyc = c; drop_d = 1'b1; end
      if (InstrReq && !InstrWait) begin i_cyc = c; break; end
      @(posedge clk); #1;
      if (drop_d) DataReq = 1'b0;
    end
    check("sim_data_done", d_cyc, 3);
    check("sim_instr_done", i_cyc, 7);
    check("sim_bus_count", bus_log.size(), 2);
    if (bus_log.size() >= 2) check("sim_bus_order", {bus_log[0], bus_log[1]}, {32'h40, 32'h200});
    @(posedge clk); #1;
    InstrReq = 1'b0; DataReq = 1'b0;
    @(posedge clk); #1;

    // Flushed fetch: address changes during RESP
    preload(32'h300, 32'hAAAA0300);
    preload(32'h400, 32'hBBBB0400);
    fixed_resp = 2;
    bus_log.delete();
    InstrAddr = 32'h300; InstrReq = 1'b1;
    exp_instr.push_back(ref_read(32'h300));
    done_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) check("flush_cmd", {bus_valid, bus_addr}, {1'b1, 32'h300});
      if (c == 5) begin
        check("flush_discard_wait", InstrWait, 1'b1);
        check("flush_discard_hold", InstrRdata, 32'hCAFE0200);
      end
      if (!InstrWait) begin done_cyc = c; break; end
      @(posedge clk); #1;
      if (c == 2) begin
        InstrAddr = 32'h400;
        exp_instr[exp_instr.size()-1] = ref_read(32'h400);
      end
    end
    check("flush_done_cycle", done_cyc, 11);
    check("flush_rdata", InstrRdata, 32'hBBBB0400);
    check("flush_bus_count", bus_log.size(), 2);
    if (bus_log.size() >= 2) check("flush_bus_order", {bus_log[0], bus_log[1]}, {32'h300, 32'h400});
    @(posedge clk); #1;
    InstrReq = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a response wait
    fixed_resp = 5;
    preload(32'h500, 32'h55550500);
    InstrAddr = 32'h500; InstrReq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_cmd", {bus_valid, bus_addr}, {1'b1, 32'h500});
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstmid_bus_valid", bus_valid, 1'b0);
    check("rstmid_bus_addr", bus_addr, 32'h0);
    check("rstmid_rdata", {InstrRdata, DataRdata}, 64'h0);
    check("rstmid_wait", InstrWait, 1'b1);
    exp_instr.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    fixed_resp = 0;
    fetch_min("fetch_after_rst", 32'h500, 32'h55550500);
    @(posedge clk); #1;

    // Randomized concurrent traffic
    rand_mode = 1'b1;
    fork
      instr_driver(40);
      data_driver(40);
    join
    repeat (10) @(posedge clk);
    #1;
    check("instr_queue_drained", exp_instr.size(), 0);
    check("data_queue_drained", exp_data.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
